spi_master_ctrl: RTL

- Single-clock SPI master for the 10-bit command/data protocol used by the design's SPI slave and RAM path.
- Serializes a 10-bit command word onto MOSI under SS_n.
- For read-data commands, captures the 8-bit reply from MISO.
- Sits between a host or test sequencer and the slave; both sides share clk, so one bit is transferred per clk cycle.

---
 rtl/spi_master_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_ctrl
//  Description : Single-clock SPI master for the 10-bit command/data protocol.
//                Sends one command word MSB first under SS_n. On read-data
//                commands (opcode 11) it captures an 8-bit reply from MISO.
//                One bit moves per clk cycle.
//  Ports       : clk      - system clock, rising edge
//                rst_n    - asynchronous active-low reset
//                start    - frame request (taken only when a frame may begin)
//                din      - [9:8] opcode, [7:0] payload
//                MISO     - serial data from slave
//                SS_n     - slave select, active-low (registered)
//                MOSI     - serial data to slave (registered)
//                busy     - frame or inter-frame gap in progress
//                done     - one-cycle pulse on the first SS_n-high cycle
//                rd_data  - last captured read byte
//                rd_valid - one-cycle pulse when rd_data is loaded
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_ctrl #(
    parameter int READ_WAIT  = 2,   // cycles between last MOSI bit and first MISO sample
    parameter int GAP_CYCLES = 1    // minimum SS_n-high cycles between frames
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [9:0] din,
    input  logic       MISO,
    output logic       SS_n,
    output logic       MOSI,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       rd_valid
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_CMD    = 3'd2,
        S_SHIFT  = 3'd3,
        S_WAIT   = 3'd4,
        S_READ   = 3'd5,
        S_END    = 3'd6,
        S_GAP    = 3'd7
    } state_t;

    // Terminal counts; guarded so out-of-use values never go negative.
    localparam logic [3:0] c_wait_last = (READ_WAIT  > 0) ? 4'(READ_WAIT - 1)  : 4'd0;
    localparam logic [3:0] c_gap_last  = (GAP_CYCLES > 1) ? 4'(GAP_CYCLES - 2) : 4'd0;

    state_t     r_state;
    logic [9:0] r_shift;
    logic [1:0] r_op;
    logic [3:0] r_cnt;
    logic [7:0] r_cap;

    logic w_last_high;
    logic w_accept;

    // The last SS_n-high cycle of a frame's tail is also a legal start point,
    // so a held start yields frames separated by exactly GAP_CYCLES high cycles
    // without busy dropping in between.
    assign w_last_high = ((r_state == S_END) && (GAP_CYCLES <= 1)) ||
                         ((r_state == S_GAP) && (r_cnt == c_gap_last));
    assign w_accept    = start && ((r_state == S_IDLE) || w_last_high);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_shift  <= 10'd0;
            r_op     <= 2'd0;
            r_cnt    <= 4'd0;
            r_cap    <= 8'd0;
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            if (w_accept) begin
                r_shift <= din;
                r_op    <= din[9:8];
                r_cnt   <= 4'd0;
                SS_n    <= 1'b0;
                MOSI    <= 1'b0;
                busy    <= 1'b1;
                r_state <= S_SELECT;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        SS_n <= 1'b1;
                        MOSI <= 1'b0;
                        busy <= 1'b0;
                    end
                    S_SELECT: begin
                        // CMD cycle presents the read/write flag.
                        MOSI    <= r_shift[9];
                        r_state <= S_CMD;
                    end
                    S_CMD: begin
                        MOSI    <= r_shift[9];
                        r_shift <= {r_shift[8:0], 1'b0};
                        r_cnt   <= 4'd0;
                        r_state <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        if (r_cnt == 4'd9) begin
                            MOSI  <= 1'b0;
                            r_cnt <= 4'd0;
                            if (r_op == 2'b11) begin
                                r_state <= (READ_WAIT == 0) ? S_READ : S_WAIT;
                            end else begin
                                SS_n    <= 1'b1;
                                done    <= 1'b1;
                                r_state <= S_END;
                            end
                        end else begin
                            MOSI    <= r_shift[9];
                            r_shift <= {r_shift[8:0], 1'b0};
                            r_cnt   <= r_cnt + 4'd1;
                        end
                    end
                    S_WAIT: begin
                        if (r_cnt == c_wait_last) begin
                            r_cnt   <= 4'd0;
                            r_state <= S_READ;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    S_READ: begin
                        r_cap <= {r_cap[6:0], MISO};
                        if (r_cnt == 4'd7) begin
                            rd_data  <= {r_cap[6:0], MISO};
                            rd_valid <= 1'b1;
                            done     <= 1'b1;
                            SS_n     <= 1'b1;
                            r_cnt    <= 4'd0;
                            r_state  <= S_END;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    S_END: begin
                        if (GAP_CYCLES > 1) begin
                            r_cnt   <= 4'd0;
                            r_state <= S_GAP;
                        end else begin
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                    S_GAP: begin
                        if (w_last_high) begin
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
